// File: rtl/vga_pixel_pipe_pkg.sv
// Shared definitions for the video-memory to RGB pixel pipe.
// Colour-depth codes, FSM state encoding and pixel unpack helpers.
package vga_pixel_pipe_pkg;

    localparam logic [1:0] CD_8   = 2'b00;
    localparam logic [1:0] CD_16  = 2'b01;
    localparam logic [1:0] CD_24  = 2'b10;
    localparam logic [1:0] CD_RSV = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PIX1,
        ST_PIX2,
        ST_PIX3,
        ST_CLUT_REQ,
        ST_CLUT_WAIT,
        ST_24P1,
        ST_24P2,
        ST_24P3
    } state_t;

    function automatic logic [23:0] grey(input logic [7:0] b);
        return {b, b, b};
    endfunction

    function automatic logic [23:0] rgb565(input logic [15:0] h);
        return {h[15:11], 3'b000, h[10:5], 2'b00, h[4:0], 3'b000};
    endfunction

    function automatic logic [7:0] byte_sel(
        input logic [31:0] w,
        input logic [1:0]  i
    );
        logic [7:0] b;
        case (i)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/vga_pixel_pipe_if.sv
// Control, pixel-FIFO write, RGB output and CLUT handshake bundle.
// master drives the pipe's inputs; slave is the pipe itself.
interface vga_pixel_pipe_if;

    logic        sclr;
    logic [1:0]  ctrl_cd;
    logic        ctrl_pc;
    logic [31:0] pix_d;
    logic        pix_wreq;
    logic        pix_hfull;
    logic        pix_full;
    logic        rgb_full;
    logic        rgb_wreq;
    logic [23:0] rgb_d;
    logic        clut_req;
    logic        clut_ack;
    logic [7:0]  clut_offs;
    logic [23:0] clut_q;

    modport master (
        output sclr, ctrl_cd, ctrl_pc, pix_d, pix_wreq,
        output rgb_full, clut_ack, clut_q,
        input  pix_hfull, pix_full, rgb_wreq, rgb_d,
        input  clut_req, clut_offs
    );

    modport slave (
        input  sclr, ctrl_cd, ctrl_pc, pix_d, pix_wreq,
        input  rgb_full, clut_ack, clut_q,
        output pix_hfull, pix_full, rgb_wreq, rgb_d,
        output clut_req, clut_offs
    );

endinterface

// File: rtl/vga_pix_fifo.sv
// Show-ahead FIFO: head word is on q whenever not empty.
// Writes while full are dropped; pointers wrap mod 2**AW.
module vga_pix_fifo #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic          sclr,
    input  logic [DW-1:0] d,
    input  logic          wreq,
    output logic [DW-1:0] q,
    input  logic          rreq,
    output logic          empty,
    output logic          hfull,
    output logic          full
);

    localparam logic [AW:0] HALF = (AW+1)'(1) << (AW-1);

    logic [DW-1:0] r_mem [0:2**AW-1];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_we;
    logic          w_re;

    assign w_we  = wreq & ~full;
    assign w_re  = rreq & ~empty;
    assign q     = r_mem[r_rp];
    assign empty = (r_cnt == '0);
    assign full  = r_cnt[AW];
    assign hfull = (r_cnt >= HALF);

    always_ff @(posedge clk_i) begin
        if (w_we) r_mem[r_wp] <= d;
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (sclr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_we) r_wp <= r_wp + 1'b1;
            if (w_re) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt
                   + {{AW{1'b0}}, w_we}
                   - {{AW{1'b0}}, w_re};
        end
    end

endmodule

// File: rtl/vga_pixel_pipe.sv
// Pixel FIFO plus colour processor: unpacks 32-bit words into RGB
// pixels for 8/16/24bpp, resolving pseudo-colour through the CLUT.
import vga_pixel_pipe_pkg::*;

module vga_pixel_pipe #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input logic        clk_i,
    input logic        nrst_i,
    vga_pixel_pipe_if.slave bus
);

    logic [DW-1:0] w_q;
    logic          w_empty;
    logic          w_pop;
    logic          w_go;
    logic          w_avail;

    state_t        r_state;
    logic [DW-1:0] r_buf;
    logic [1:0]    r_idx;
    logic [23:0]   r_rgb_d;
    logic          r_rgb_wreq;
    logic          r_clut_req;
    logic [7:0]    r_clut_offs;

    assign w_go    = ~bus.sclr & ~bus.rgb_full;
    assign w_avail = w_go & ~w_empty;

    assign bus.rgb_d     = r_rgb_d;
    assign bus.rgb_wreq  = r_rgb_wreq;
    assign bus.clut_req  = r_clut_req;
    assign bus.clut_offs = r_clut_offs;

    vga_pix_fifo #(.AW(AW), .DW(DW)) u_fifo (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .sclr   (bus.sclr),
        .d      (bus.pix_d),
        .wreq   (bus.pix_wreq),
        .q      (w_q),
        .rreq   (w_pop),
        .empty  (w_empty),
        .hfull  (bus.pix_hfull),
        .full   (bus.pix_full)
    );

    // A word is consumed only where its bytes complete a pixel this cycle.
    always_comb begin
        w_pop = 1'b0;
        unique case (r_state)
            ST_IDLE:          w_pop = w_avail & (bus.ctrl_cd != CD_RSV);
            ST_24P1, ST_24P2: w_pop = w_avail;
            default:          w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state     <= ST_IDLE;
            r_buf       <= '0;
            r_idx       <= '0;
            r_rgb_d     <= '0;
            r_rgb_wreq  <= 1'b0;
            r_clut_req  <= 1'b0;
            r_clut_offs <= '0;
        end else if (bus.sclr) begin
            r_state     <= ST_IDLE;
            r_buf       <= '0;
            r_idx       <= '0;
            r_rgb_d     <= '0;
            r_rgb_wreq  <= 1'b0;
            r_clut_req  <= 1'b0;
            r_clut_offs <= '0;
        end else begin
            r_rgb_wreq <= 1'b0;
            unique case (r_state)
                ST_IDLE: if (w_pop) begin
                    r_buf <= w_q;
                    if (bus.ctrl_cd == CD_24) begin
                        r_rgb_d    <= w_q[31:8];
                        r_rgb_wreq <= 1'b1;
                        r_state    <= ST_24P1;
                    end else if (bus.ctrl_cd == CD_16) begin
                        r_rgb_d    <= rgb565(w_q[31:16]);
                        r_rgb_wreq <= 1'b1;
                        r_state    <= ST_PIX1;
                    end else if (bus.ctrl_pc) begin
                        r_clut_req  <= 1'b1;
                        r_clut_offs <= w_q[31:24];
                        r_idx       <= 2'd0;
                        r_state     <= ST_CLUT_WAIT;
                    end else begin
                        r_rgb_d    <= grey(w_q[31:24]);
                        r_rgb_wreq <= 1'b1;
                        r_state    <= ST_PIX1;
                    end
                end
                ST_PIX1: if (w_go) begin
                    r_rgb_wreq <= 1'b1;
                    if (bus.ctrl_cd == CD_16) begin
                        r_rgb_d <= rgb565(r_buf[15:0]);
                        r_state <= ST_IDLE;
                    end else begin
                        r_rgb_d <= grey(r_buf[23:16]);
                        r_state <= ST_PIX2;
                    end
                end
                ST_PIX2: if (w_go) begin
                    r_rgb_d    <= grey(r_buf[15:8]);
                    r_rgb_wreq <= 1'b1;
                    r_state    <= ST_PIX3;
                end
                ST_PIX3: if (w_go) begin
                    r_rgb_d    <= grey(r_buf[7:0]);
                    r_rgb_wreq <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                ST_CLUT_REQ: if (w_go) begin
                    r_clut_req  <= 1'b1;
                    r_clut_offs <= byte_sel(r_buf, r_idx);
                    r_state     <= ST_CLUT_WAIT;
                end
                ST_CLUT_WAIT: if (bus.clut_ack) begin
                    r_rgb_d    <= bus.clut_q;
                    r_rgb_wreq <= 1'b1;
                    r_clut_req <= 1'b0;
                    r_idx      <= r_idx + 2'd1;
                    r_state    <= (r_idx == 2'd3) ? ST_IDLE : ST_CLUT_REQ;
                end
                ST_24P1: if (w_pop) begin
                    r_rgb_d    <= {r_buf[7:0], w_q[31:16]};
                    r_rgb_wreq <= 1'b1;
                    r_buf      <= w_q;
                    r_state    <= ST_24P2;
                end
                ST_24P2: if (w_pop) begin
                    r_rgb_d    <= {r_buf[15:0], w_q[31:24]};
                    r_rgb_wreq <= 1'b1;
                    r_buf      <= w_q;
                    r_state    <= ST_24P3;
                end
                ST_24P3: if (w_go) begin
                    r_rgb_d    <= r_buf[23:0];
                    r_rgb_wreq <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Directed bench for vga_pixel_pipe: grey, RGB565, 24bpp, CLUT,
// FIFO fill/backpressure, synchronous clear and async reset.
module tb_vga_pixel_pipe;
    import vga_pixel_pipe_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    vga_pixel_pipe_if bus();

    vga_pixel_pipe #(.AW(4), .DW(32)) dut (
        .clk_i  (clk),
        .nrst_i (nrst),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wcyc = 0;
    logic [23:0] pq[$];
    int pcyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (nrst && bus.rgb_wreq === 1'b1) begin
            pq.push_back(bus.rgb_d);
            pcyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic write_word(input logic [31:0] w);
        bus.pix_d = w;
        bus.pix_wreq = 1'b1;
        @(negedge clk);
        bus.pix_wreq = 1'b0;
        wcyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pix(input int n, input int budget);
        int t;
        t = 0;
        while (pq.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        idle(2);
    endtask

    task automatic set_mode(input logic [1:0] cd, input logic pcm,
                            input logic rf);
        bus.sclr = 1'b1;
        bus.ctrl_cd = cd;
        bus.ctrl_pc = pcm;
        bus.rgb_full = rf;
        @(negedge clk);
        bus.sclr = 1'b0;
        pq.delete();
        pcyc.delete();
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.rgb_wreq, bus.clut_req, bus.pix_hfull, bus.pix_full}
            !== 4'b0000) begin
            $display("FAIL reset_flags got %b exp 0000",
                {bus.rgb_wreq, bus.clut_req, bus.pix_hfull, bus.pix_full});
            errors++;
        end
        checks++;
        if ({bus.clut_offs, bus.rgb_d} !== 32'h0) begin
            $display("FAIL reset_data got %h exp 0",
                {bus.clut_offs, bus.rgb_d});
            errors++;
        end
    endtask

    task automatic test_grey();
        logic [23:0] exp [4];
        logic [23:0] got;
        exp = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
        set_mode(CD_8, 1'b0, 1'b0);
        write_word(32'h11223344);
        wait_pix(4, 20);
        checks++;
        if (pq.size() != 4) begin
            $display("FAIL grey_count got %0d exp 4", pq.size());
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < pq.size()) ? pq[i] : 24'hxxxxxx;
            checks++;
            if (got !== exp[i]) begin
                $display("FAIL grey_pix%0d got %h exp %h", i, got, exp[i]);
                errors++;
            end
        end
        checks++;
        if (pcyc.size() < 1 || pcyc[0] != wcyc + 1) begin
            $display("FAIL grey_latency got %0d exp %0d",
                (pcyc.size() > 0) ? pcyc[0] : -1, wcyc + 1);
            errors++;
        end
        checks++;
        if (pcyc.size() < 4 || pcyc[3] - pcyc[0] != 3) begin
            $display("FAIL grey_b2b got span %0d exp 3",
                (pcyc.size() > 3) ? pcyc[3] - pcyc[0] : -1);
            errors++;
        end
    endtask

    task automatic test_rgb565();
        logic [23:0] exp [2];
        logic [23:0] got;
        exp = '{24'hF80000, 24'h00FC00};
        set_mode(CD_16, 1'b0, 1'b0);
        write_word(32'hF80007E0);
        wait_pix(2, 20);
        checks++;
        if (pq.size() != 2) begin
            $display("FAIL rgb565_count got %0d exp 2", pq.size());
            errors++;
        end
        for (int i = 0; i < 2; i++) begin
            got = (i < pq.size()) ? pq[i] : 24'hxxxxxx;
            checks++;
            if (got !== exp[i]) begin
                $display("FAIL rgb565_pix%0d got %h exp %h", i, got, exp[i]);
                errors++;
            end
        end
    endtask

    task automatic run_24bpp(input string tag);
        logic [23:0] exp [4];
        logic [23:0] got;
        exp = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
        write_word(32'h01020304);
        write_word(32'h05060708);
        write_word(32'h090A0B0C);
        wait_pix(4, 20);
        checks++;
        if (pq.size() != 4) begin
            $display("FAIL %s_count got %0d exp 4", tag, pq.size());
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < pq.size()) ? pq[i] : 24'hxxxxxx;
            checks++;
            if (got !== exp[i]) begin
                $display("FAIL %s_pix%0d got %h exp %h", tag, i, got, exp[i]);
                errors++;
            end
        end
        checks++;
        if (pcyc.size() < 4 || pcyc[3] - pcyc[0] != 3) begin
            $display("FAIL %s_b2b got span %0d exp 3", tag,
                (pcyc.size() > 3) ? pcyc[3] - pcyc[0] : -1);
            errors++;
        end
    endtask

    task automatic test_24bpp();
        set_mode(CD_24, 1'b0, 1'b0);
        run_24bpp("bpp24");
    endtask

    task automatic test_clut();
        logic [7:0] offs [4];
        int t;
        offs = '{8'h00, 8'hFF, 8'h10, 8'h80};
        set_mode(CD_8, 1'b1, 1'b0);
        write_word(32'h00FF1080);
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (bus.clut_req !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (bus.clut_req !== 1'b1) begin
                $display("FAIL clut_req%0d got timeout exp req", k);
                errors++;
                break;
            end
            checks++;
            if (bus.clut_offs !== offs[k]) begin
                $display("FAIL clut_offs%0d got %h exp %h",
                    k, bus.clut_offs, offs[k]);
                errors++;
            end
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                checks++;
                if (bus.clut_req !== 1'b1 || bus.clut_offs !== offs[k]) begin
                    $display("FAIL clut_hold%0d got %b/%h exp 1/%h",
                        k, bus.clut_req, bus.clut_offs, offs[k]);
                    errors++;
                end
            end
            @(negedge clk);
            bus.clut_ack = 1'b1;
            bus.clut_q = 24'hABCDEF;
            @(negedge clk);
            bus.clut_ack = 1'b0;
            bus.clut_q = 24'h000000;
            checks++;
            if (bus.clut_req !== 1'b0) begin
                $display("FAIL clut_drop%0d got %b exp 0", k, bus.clut_req);
                errors++;
            end
        end
        idle(4);
        checks++;
        if (pq.size() != 4) begin
            $display("FAIL clut_count got %0d exp 4", pq.size());
            errors++;
        end
        for (int i = 0; i < pq.size(); i++) begin
            checks++;
            if (pq[i] !== 24'hABCDEF) begin
                $display("FAIL clut_pix%0d got %h exp abcdef", i, pq[i]);
                errors++;
            end
        end
    endtask

    task automatic test_full();
        logic [7:0] b;
        logic [23:0] got;
        set_mode(CD_8, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            write_word({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
            checks++;
            if (bus.pix_hfull !== (i >= 7)) begin
                $display("FAIL hfull_w%0d got %b exp %b",
                    i + 1, bus.pix_hfull, (i >= 7));
                errors++;
            end
            checks++;
            if (bus.pix_full !== (i == 15)) begin
                $display("FAIL full_w%0d got %b exp %b",
                    i + 1, bus.pix_full, (i == 15));
                errors++;
            end
        end
        write_word(32'hEEEEEEEE);
        idle(3);
        checks++;
        if (pq.size() != 0) begin
            $display("FAIL full_hold got %0d pixels exp 0", pq.size());
            errors++;
        end
        bus.rgb_full = 1'b0;
        wait_pix(64, 200);
        idle(5);
        checks++;
        if (pq.size() != 64) begin
            $display("FAIL full_count got %0d exp 64", pq.size());
            errors++;
        end
        for (int i = 0; i < 64; i++) begin
            b = 8'(i);
            got = (i < pq.size()) ? pq[i] : 24'hxxxxxx;
            checks++;
            if (got !== {b, b, b}) begin
                $display("FAIL full_pix%0d got %h exp %h", i, got, {b, b, b});
                errors++;
            end
        end
        checks++;
        if ({bus.pix_hfull, bus.pix_full} !== 2'b00) begin
            $display("FAIL drained got %b exp 00",
                {bus.pix_hfull, bus.pix_full});
            errors++;
        end
    endtask

    task automatic test_sclr();
        set_mode(CD_24, 1'b0, 1'b0);
        write_word(32'h01020304);
        idle(4);
        checks++;
        if (pq.size() != 1 || pq[0] !== 24'h010203) begin
            $display("FAIL sclr_w0 got %0d/%h exp 1/010203",
                pq.size(), (pq.size() > 0) ? pq[0] : 24'h0);
            errors++;
        end
        set_mode(CD_24, 1'b0, 1'b0);
        run_24bpp("sclr24");
    endtask

    task automatic test_async_reset();
        int t;
        set_mode(CD_8, 1'b0, 1'b0);
        write_word(32'h11223344);
        write_word(32'h55667788);
        t = 0;
        while (bus.rgb_wreq !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bus.rgb_wreq !== 1'b1) begin
            $display("FAIL arst_pre got timeout exp wreq");
            errors++;
        end
        #1 nrst = 1'b0;
        #1;
        checks++;
        if ({bus.rgb_wreq, bus.clut_req, bus.pix_hfull, bus.pix_full}
            !== 4'b0000) begin
            $display("FAIL arst_flags got %b exp 0000",
                {bus.rgb_wreq, bus.clut_req, bus.pix_hfull, bus.pix_full});
            errors++;
        end
        checks++;
        if ({bus.clut_offs, bus.rgb_d} !== 32'h0) begin
            $display("FAIL arst_data got %h exp 0",
                {bus.clut_offs, bus.rgb_d});
            errors++;
        end
        @(negedge clk);
        nrst = 1'b1;
        pq.delete();
        idle(6);
        checks++;
        if (pq.size() != 0) begin
            $display("FAIL arst_flush got %0d pixels exp 0", pq.size());
            errors++;
        end
    endtask

    initial begin
        bus.sclr = 1'b0;
        bus.ctrl_cd = CD_8;
        bus.ctrl_pc = 1'b0;
        bus.pix_d = 32'h0;
        bus.pix_wreq = 1'b0;
        bus.rgb_full = 1'b0;
        bus.clut_ack = 1'b0;
        bus.clut_q = 24'h0;
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        nrst = 1'b1;
        @(negedge clk);
        test_grey();
        test_rgb565();
        test_24bpp();
        test_clut();
        test_full();
        test_sclr();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
